// File: rtl/bcd_to_binary.sv
// Packed-BCD to binary converter (reverse double-dabble: shift right, then
// subtract 3 from every BCD nibble that reads 8 or more).
// One result per accepted start; all outputs come straight from flops.
//
// state  | meaning
// IDLE   | waiting for start; invalid-digit requests are answered here
// CONV   | performing BIN_W shift/adjust iterations
module bcd_to_binary #(
  parameter int N_DIGITS  = 3,
  parameter int BIN_W     = 10,
  parameter int OVF_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  ovf,
  output logic                  err,
  output logic                  busy,
  output logic                  done
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] OVF_LIM_W = BIN_W'(OVF_LIMIT);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SR_W-1:0]  sr_shift;
  logic [SR_W-1:0]  sr_adj;
  logic             digit_bad;

  // One iteration: shift whole register right, then correct each BCD nibble.
  always_comb begin
    sr_shift = sr_q >> 1;
    sr_adj   = sr_shift;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (sr_shift[BIN_W + 4*i +: 4] >= 4'd8)
        sr_adj[BIN_W + 4*i +: 4] = sr_shift[BIN_W + 4*i +: 4] - 4'd3;
    end
  end

  // Flag any incoming digit outside 0..9.
  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9)
        digit_bad = 1'b1;
    end
  end

  // Next-state logic for the sequencer and result registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (digit_bad) begin
            // Bad input is answered immediately with a zero result.
            bin_d = '0;
            ovf_d = 1'b0;
            err_d = 1'b1;
            done_d = 1'b1;
          end else begin
            sr_d    = {bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_CONV;
          end
        end
      end
      S_CONV: begin
        sr_d  = sr_adj;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          bin_d   = sr_adj[BIN_W-1:0];
          ovf_d   = (sr_adj[BIN_W-1:0] > OVF_LIM_W);
          err_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bin_out = bin_q;
  assign ovf     = ovf_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
